// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin scheduler sharing one pipelined multiplier
// (mult_man) among REQ requesters. A {valid, id} tag travels alongside the
// multiplier pipeline so each product is steered back to its originator.
// Optional feature macro: MULT_SHARE_ARB_CHECK_EN enables a sticky err flag
// that fires when the tag pipeline head disagrees with mul_res_rdy.
module mult_share_arb #(
    parameter int N   = 8,
    parameter int M   = 4,
    parameter int REQ = 4,
    parameter int LAT = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             arb_en,
    input  logic [REQ-1:0]   req_vld,
    output logic [REQ-1:0]   req_rdy,
    input  logic [REQ*N-1:0] req_mult1,
    input  logic [REQ*M-1:0] req_mult2,
    output logic             mul_data_rdy,
    output logic [N-1:0]     mul_mult1,
    output logic [M-1:0]     mul_mult2,
    input  logic             mul_res_rdy,
    input  logic [N+M-1:0]   mul_res,
    output logic [REQ-1:0]   rsp_vld,
    output logic [IDW-1:0]   rsp_id,
    output logic [N+M-1:0]   rsp_res,
    output logic             busy,
    output logic             err
);

    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] grant_id;
    logic [REQ-1:0] grant;
    logic           xfer;

    logic [IDW-1:0] iss_id_reg;
    logic [LAT-1:0] tag_vld_reg;
    logic [IDW-1:0] tag_id_reg [LAT];

    // Round-robin search: first valid requester upward from ptr+1, with wrap
    always_comb begin
        int  idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= REQ) begin
                idx = idx - REQ;
            end
            if (!found && req_vld[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
                found      = 1'b1;
            end
        end
        req_rdy = arb_en ? grant : '0;
    end

    // A grant is only ever given to a valid requester, so any grant is a transfer
    assign xfer = |req_rdy;

    // Priority pointer: remembers the last requester served
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_reg <= IDW'(REQ - 1);
        end else if (xfer) begin
            ptr_reg <= grant_id;
        end
    end

    // Issue stage: present granted operands to the multiplier one cycle after transfer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mul_data_rdy <= 1'b0;
            mul_mult1    <= '0;
            mul_mult2    <= '0;
            iss_id_reg   <= '0;
        end else begin
            mul_data_rdy <= xfer;
            if (xfer) begin
                mul_mult1  <= req_mult1[grant_id*N +: N];
                mul_mult2  <= req_mult2[grant_id*M +: M];
                iss_id_reg <= grant_id;
            end
        end
    end

    // Tag stage 0: captures the issue stage as the multiplier samples data_rdy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_vld_reg[0] <= 1'b0;
            tag_id_reg[0]  <= '0;
        end else begin
            tag_vld_reg[0] <= mul_data_rdy;
            tag_id_reg[0]  <= iss_id_reg;
        end
    end

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
            // Tag stage gi: plain shift, matching the multiplier's fixed latency
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    tag_vld_reg[gi] <= 1'b0;
                    tag_id_reg[gi]  <= '0;
                end else begin
                    tag_vld_reg[gi] <= tag_vld_reg[gi-1];
                    tag_id_reg[gi]  <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    // Response stage: register the product together with its owner's strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_vld <= '0;
            rsp_id  <= '0;
            rsp_res <= '0;
        end else begin
            rsp_vld <= tag_vld_reg[LAT-1] ? (REQ'(1) << tag_id_reg[LAT-1]) : '0;
            if (tag_vld_reg[LAT-1]) begin
                rsp_id  <= tag_id_reg[LAT-1];
                rsp_res <= mul_res;
            end
        end
    end

    assign busy = mul_data_rdy | (|tag_vld_reg) | (|rsp_vld);

`ifdef MULT_SHARE_ARB_CHECK_EN
    // Sticky alignment check: the tag head must track the multiplier's result strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (tag_vld_reg[LAT-1] != mul_res_rdy) begin
            err <= 1'b1;
        end
    end
`else
    // Without the checker the result strobe is not needed; responses follow the tag
    logic unused_res_rdy;
    assign unused_res_rdy = mul_res_rdy;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Testbench for mult_share_arb: a behavioural mult_man stand-in, a round-robin
// reference model that predicts grants, and a scoreboard whose expected
// responses are consumed by an independent monitor process.
module tb_mult_share_arb;
    localparam int N   = 8;
    localparam int M   = 4;
    localparam int REQ = 4;
    localparam int LAT = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             arb_en = 1'b0;
    logic [REQ-1:0]   req_vld = '0;
    logic [REQ-1:0]   req_rdy;
    logic [REQ*N-1:0] req_mult1 = '0;
    logic [REQ*M-1:0] req_mult2 = '0;
    logic             mul_data_rdy;
    logic [N-1:0]     mul_mult1;
    logic [M-1:0]     mul_mult2;
    logic             mul_res_rdy;
    logic [N+M-1:0]   mul_res;
    logic [REQ-1:0]   rsp_vld;
    logic [IDW-1:0]   rsp_id;
    logic [N+M-1:0]   rsp_res;
    logic             busy;
    logic             err;

    mult_share_arb #(.N(N), .M(M), .REQ(REQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rstn(rstn), .arb_en(arb_en),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_mult1(req_mult1), .req_mult2(req_mult2),
        .mul_data_rdy(mul_data_rdy), .mul_mult1(mul_mult1), .mul_mult2(mul_mult2),
        .mul_res_rdy(mul_res_rdy), .mul_res(mul_res),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_res(rsp_res),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // mult_man stand-in: fixed LAT-cycle pipeline, shares rstn
    logic [LAT-1:0] pv;
    logic [N+M-1:0] pp [LAT];
    logic           force_rdy = 1'b0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv <= '0;
            for (int k = 0; k < LAT; k++) pp[k] <= '0;
        end else begin
            pv[0] <= mul_data_rdy;
            pp[0] <= (N+M)'(mul_mult1) * (N+M)'(mul_mult2);
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pp[k] <= pp[k-1];
            end
        end
    end
    assign mul_res_rdy = pv[LAT-1] | force_rdy;
    assign mul_res     = pp[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int             id;
        logic [N+M-1:0] res;
        int             due;
    } exp_t;
    exp_t q[$];

    // Requester-side state and reference model
    logic           pend [REQ];
    logic [N-1:0]   op1  [REQ];
    logic [M-1:0]   op2  [REQ];
    logic           refill = 1'b0;
    logic           en = 1'b0;
    int             mptr = REQ - 1;
    logic           prev_vld = 1'b0;
    logic [N-1:0]   prev_a = '0;
    logic [M-1:0]   prev_b = '0;
    logic           mon_on = 1'b0;

    // One cycle of stimulus: drive, check issue stage, predict grant, push expectation
    task automatic step();
        int g;
        @(negedge clk);
        for (int i = 0; i < REQ; i++) begin
            req_vld[i]           = pend[i];
            req_mult1[i*N +: N]  = op1[i];
            req_mult2[i*M +: M]  = op2[i];
        end
        arb_en = en;
        #1;
        chk("issue_data_rdy", 64'(mul_data_rdy), 64'(prev_vld));
        if (prev_vld) begin
            chk("issue_mult1", 64'(mul_mult1), 64'(prev_a));
            chk("issue_mult2", 64'(mul_mult2), 64'(prev_b));
        end
        g = -1;
        if (en) begin
            for (int k = 1; k <= REQ; k++) begin
                if (g < 0 && pend[(mptr + k) % REQ]) g = (mptr + k) % REQ;
            end
        end
        chk("req_rdy", 64'(req_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
        prev_vld = (g >= 0);
        if (g >= 0) begin
            exp_t e;
            e.id  = g;
            e.res = (N+M)'(op1[g]) * (N+M)'(op2[g]);
            e.due = cyc + LAT + 2;
            q.push_back(e);
            $display("xfer req=%0d a=%0d b=%0d exp=%0d due=%0d", g, op1[g], op2[g], e.res, e.due);
            prev_a = op1[g];
            prev_b = op2[g];
            mptr   = g;
            pend[g] = refill;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: busy model and in-order response checking
    always @(negedge clk) begin
        if (rstn && mon_on) begin
            logic bexp;
            bexp = 1'b0;
            foreach (q[j]) begin
                if (q[j].due - LAT - 1 <= cyc && cyc <= q[j].due) bexp = 1'b1;
            end
            chk("busy", 64'(busy), 64'(bexp));
            if (rsp_vld != '0) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("rsp vld=%b id=%0d res=%0d (exp id=%0d res=%0d)", rsp_vld, rsp_id, rsp_res, e.id, e.res);
                    chk("rsp_vld", 64'(rsp_vld), 64'd1 << e.id);
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_res", 64'(rsp_res), 64'(e.res));
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rsp_missing", 64'd0, 64'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_rdy"}, 64'(req_rdy), 64'd0);
        chk({tag, "_data_rdy"}, 64'(mul_data_rdy), 64'd0);
        chk({tag, "_mult1"}, 64'(mul_mult1), 64'd0);
        chk({tag, "_mult2"}, 64'(mul_mult2), 64'd0);
        chk({tag, "_rsp_vld"}, 64'(rsp_vld), 64'd0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        chk({tag, "_rsp_res"}, 64'(rsp_res), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    task automatic clear_pend();
        for (int i = 0; i < REQ; i++) pend[i] = 1'b0;
    endtask

    initial begin
        clear_pend();
        for (int i = 0; i < REQ; i++) begin
            op1[i] = '0;
            op2[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn   = 1'b1;
        mon_on = 1'b1;
        en     = 1'b1;

        // Single requester 0: 25*5
        pend[0] = 1'b1; op1[0] = 8'd25; op2[0] = 4'd5;
        step();
        idle(LAT + 4);

        // All four continuously valid for 8 cycles
        refill = 1'b1;
        for (int i = 0; i < REQ; i++) begin
            pend[i] = 1'b1; op1[i] = N'(10 + i); op2[i] = M'(i + 1);
        end
        idle(8);
        refill = 1'b0;
        clear_pend();
        idle(LAT + 4);

        // ptr=1, then requesters 1 and 3 valid: 3 wins first, 255*15 untruncated
        pend[1] = 1'b1; op1[1] = 8'd7; op2[1] = 4'd3;
        step();
        pend[1] = 1'b1; op1[1] = 8'd9;   op2[1] = 4'd2;
        pend[3] = 1'b1; op1[3] = 8'd255; op2[3] = 4'd15;
        idle(2);
        idle(LAT + 4);

        // arb_en drops after two transfers with all requesters pending
        for (int i = 0; i < REQ; i++) begin
            pend[i] = 1'b1; op1[i] = N'(3 * i + 1); op2[i] = M'(15 - i);
        end
        idle(2);
        en = 1'b0;
        idle(3);
        clear_pend();
        en = 1'b1;
        idle(LAT + 4);

        // Reset three cycles after a transfer: results discarded, ptr restarts
        pend[2] = 1'b1; op1[2] = 8'd100; op2[2] = 4'd9;
        step();
        idle(3);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        mptr     = REQ - 1;
        prev_vld = 1'b0;
        idle(2);
        @(negedge clk);
        rstn = 1'b1;
        idle(LAT + 3);
        pend[0] = 1'b1; op1[0] = 8'd12; op2[0] = 4'd11;
        pend[2] = 1'b1; op1[2] = 8'd13; op2[2] = 4'd6;
        idle(2);
        idle(LAT + 4);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 4) begin
                    pend[i] = 1'b1;
                    op1[i]  = N'($urandom);
                    op2[i]  = M'($urandom);
                end
            end
            en = ($urandom_range(0, 9) != 0);
            step();
        end
        clear_pend();
        en = 1'b1;
        idle(LAT + 6);
        chk("queue_drained", 64'(q.size()), 64'd0);

        // Misaligned result strobe with nothing in flight
        step();
        force_rdy = 1'b1;
        step();
        force_rdy = 1'b0;
`ifdef MULT_SHARE_ARB_CHECK_EN
        chk("err_set", 64'(err), 64'd1);
        idle(3);
        chk("err_sticky", 64'(err), 64'd1);
`else
        chk("err_off", 64'(err), 64'd0);
        idle(3);
        chk("err_off_hold", 64'(err), 64'd0);
`endif
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("err_reset", 64'(err), 64'd0);
        mptr     = REQ - 1;
        prev_vld = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin scheduler that shares one pipelined multiplier instance (`mult_man`, N x M bits, fixed LAT-cycle latency, no stall) among REQ requesters.
- Accepts operand pairs through per-requester valid/ready handshakes and issues at most one operation per cycle to the multiplier.
- Carries a requester-ID tag alongside the multiplier pipeline and steers each product back to its originator.
- Sits between the requesting units and `mult_man`.

Parameters:
- N, 8, width of operand mult1
- M, 4, width of operand mult2
- REQ, 4, number of requesters (2..8)
- LAT, 4, multiplier pipeline latency in cycles, data_rdy to res_rdy; equals M for `mult_man`
- IDW, 2, tag width, $clog2(REQ)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- arb_en  in  1  issue enable; when low, no new grants are made
- req_vld  in  REQ  per-requester operand valid
- req_rdy  out  REQ  per-requester grant, one-hot or zero
- req_mult1  in  REQ*N  packed operand 1; requester i uses [i*N +: N]
- req_mult2  in  REQ*M  packed operand 2; requester i uses [i*M +: M]
- mul_data_rdy  out  1  to mult_man data_rdy
- mul_mult1  out  N  to mult_man mult1
- mul_mult2  out  M  to mult_man mult2
- mul_res_rdy  in  1  from mult_man res_rdy
- mul_res  in  N+M  from mult_man res
- rsp_vld  out  REQ  one-hot result strobe, one cycle
- rsp_id  out  IDW  requester index of the current result
- rsp_res  out  N+M  product
- busy  out  1  high while any operation is in flight
- err  out  1  sticky tag/result misalignment flag

Behaviour:
- Reset (async, rstn=0):
  - all outputs 0; mul_mult1/mul_mult2/rsp_res/rsp_id = 0.
  - Round-robin pointer = REQ-1, so requester 0 has first priority.
  - Tag pipeline cleared; err cleared.
  - `mult_man` shares rstn.
- Arbitration (combinational):
  - req_rdy[i] = arb_en & req_vld[i] & (i is the first valid index searching upward, with wrap, from ptr+1).
  - req_rdy is never asserted for a non-valid requester.
  - At most one bit of req_rdy is set.
- Handshake: transfer when req_vld[i] & req_rdy[i] at posedge T.
  - Requesters hold operands stable until the transfer.
  - ptr <= i on transfer; ptr is unchanged when there is no transfer.
- Issue (registered):
  - At T+1: mul_data_rdy=1, mul_mult1/mul_mult2 = the granted operands.
  - mul_data_rdy=0 on cycles with no transfer; operand regs hold their last value.
- Throughput: one transfer per cycle sustained; no bubbles.
- Fairness: under continuous all-valid requests the grant order is 0,1,...,REQ-1,0,...
  - A valid requester waits at most REQ-1 cycles.
- Tag pipeline:
  - LAT-stage shift register of {valid, id}, loaded at T+1 with {1, i}.
  - Head aligns with mul_res_rdy at T+1+LAT.
- Response (registered):
  - At T+2+LAT: rsp_vld = onehot(head id) when head valid; rsp_id = head id; rsp_res = mul_res.
  - Total latency from handshake edge to rsp_vld = LAT+2 cycles.
  - rsp_res/rsp_id hold their last value when rsp_vld=0.
  - Requesters cannot back-pressure responses.
- busy = OR of the issue stage valid, all tag-stage valids and the response stage valid.
  - Deasserts the cycle after the last rsp_vld.
- arb_en low: req_rdy=0 immediately; in-flight operations drain normally.
- Arithmetic: the product is unsigned, N+M bits, never truncated; this block passes mul_res through unmodified.
- Reset mid-operation: all in-flight results are discarded; no rsp_vld after rstn rises until new transfers complete.
- Simultaneous transfer and response in the same cycle are independent.

Optional Feature:
- MULT_SHARE_ARB_CHECK_EN
  - Defined: at each cycle, compare tag head valid against mul_res_rdy. Any mismatch sets err=1 at the next edge; err stays set until reset. rsp_vld follows the tag only.
  - Undefined: no comparison logic; err tied to 0.

Test Plan:
- Single requester 0, mult1=25, mult2=5, transfer at T -> rsp_vld=4'b0001, rsp_id=0, rsp_res=125 at T+6; busy high T+1..T+6.
- All four valid continuously for 8 cycles, operands (10+i, i+1) -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; responses back-to-back in the same order, products 10, 22, 36, 52.
- Requesters 1 and 3 valid, ptr=1 -> grant 3 first, then 1; requester 3 with 255*15 returns 3825, with no truncation.
- arb_en dropped after 2 transfers while all requests are pending -> req_rdy=0 immediately; the 2 results still arrive; busy falls the cycle after the last rsp_vld.
- rstn pulsed low 3 cycles after a transfer -> all outputs 0 asynchronously; no rsp_vld afterwards; the next transfer after release completes normally with ptr reset (requester 0 first).
- With MULT_SHARE_ARB_CHECK_EN defined, force mul_res_rdy=1 with no transfer in flight -> err=1 on the next edge and held until reset; with the macro undefined, err stays 0.
